// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with an internal oversampling tick divider.
// Bytes are presented through a valid/ack holding register with sticky overrun and a framing-error pulse.
module uart_rx_oversampled #(
   parameter int TICK_DIV   = 2604,
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 overrun,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   state_t               next_state;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 rx_d;
   logic                 fall;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [OS_W-1:0]      tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 half_done;
   logic                 bit_done;
   logic                 phase_end;
   logic                 shift_en;
   logic                 load;
   logic                 bad_stop;

   // Synchroniser plus one delay stage for edge detection; idle-high reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign fall      = !rx_s && rx_d;
   assign tick      = (div_cnt == DIV_LAST);
   assign half_done = tick && (tick_cnt == HALF_LAST);
   assign bit_done  = tick && (tick_cnt == FULL_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:  if (fall) next_state = START;
         START: if (half_done) next_state = rx_s ? IDLE : DATA;
         DATA:  if (bit_done && (bit_cnt == BITS_LAST)) next_state = STOP;
         STOP:  if (bit_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      phase_end = (next_state != state);
      shift_en  = (state == DATA) && bit_done;
      load      = (state == STOP) && bit_done && rx_s;
      bad_stop  = (state == STOP) && bit_done && !rx_s;
   end

   // Divider is parked at zero in IDLE so the first tick lands TICK_DIV cycles after the start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (state == IDLE || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         if (state == IDLE || phase_end) begin
            tick_cnt <= '0;
         end else if (tick) begin
            tick_cnt <= (tick_cnt == FULL_LAST) ? '0 : tick_cnt + OS_W'(1);
         end
         if (state != DATA) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
         if (shift_en) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         end
      end
   end

   // A simultaneous ack consumes the old byte, so the new load is not an overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= bad_stop;
         if (load) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_ack) begin
               overrun <= 1'b1;
            end else if (rx_valid && rx_ack) begin
               overrun <= 1'b0;
            end
         end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule
